// File: rtl/fir_tap_engine_if.sv
// rtl/fir_tap_engine_if.sv - sample/coefficient/result bundle for fir_tap_engine
interface fir_tap_engine_if #(
    parameter int CA_W = 10
);
    logic                   sequencing;
    logic signed [15:0]     smpl_in;
    logic [CA_W-1:0]        coeff_addr;
    logic signed [15:0]     coeff;
    logic signed [15:0]     smpl_out;
    logic                   valid;
    logic                   overrun;

    // engine side
    modport slave (
        input  sequencing, smpl_in, coeff,
        output coeff_addr, smpl_out, valid, overrun
    );

    // queue / ROM / consumer side
    modport master (
        output sequencing, smpl_in, coeff,
        input  coeff_addr, smpl_out, valid, overrun
    );
endinterface

// File: rtl/fir_tap_engine.sv
// rtl/fir_tap_engine.sv - frame-based MAC with round-half-up and output saturation
module fir_tap_engine #(
    parameter int N_TAPS = 1021,
    parameter int CA_W   = 10,
    parameter int ACC_W  = 42,
    parameter int SHIFT  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    fir_tap_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CA_W-1:0]         LAST   = CA_W'(N_TAPS - 1);
    localparam logic signed [ACC_W-1:0] HALF   = ACC_W'(1) <<< (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

    state_t                   state_q, state_d;
    logic                     seq_q;
    logic                     rise;
    logic                     start;
    logic [CA_W-1:0]          addr_q;
    logic [CA_W-1:0]          tap_q;
    logic signed [31:0]       prod_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  rounded;
    logic signed [15:0]       sat_val;
    logic                     acc_en;

    assign rise  = bus.sequencing & ~seq_q;
    assign start = rise && (state_q == IDLE);

    // Address 0 must be on the ROM bus in the start cycle itself, before any register can update.
    assign bus.coeff_addr = start ? '0 : addr_q;

    // The first product of a frame is only valid from the second RUN cycle onward.
    assign acc_en = ((state_q == RUN) && (tap_q != '0)) || (state_q == DRAIN);

    // Registered copy of sequencing for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seq_q <= 1'b0;
        else        seq_q <= bus.sequencing;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: the frame is count-driven once started.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (tap_q == LAST) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Tap counter and ROM address; address saturates at the last tap and holds while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q  <= '0;
            addr_q <= '0;
        end else if (start) begin
            tap_q  <= '0;
            addr_q <= CA_W'(1);
        end else if (state_q == RUN) begin
            tap_q <= tap_q + 1'b1;
            if (addr_q != LAST) addr_q <= addr_q + 1'b1;
        end
    end

    // Multiply stage: sample k meets coeff[k] one cycle after its address was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                prod_q <= '0;
        else if (state_q == RUN)   prod_q <= 32'(bus.smpl_in) * 32'(bus.coeff);
    end

    // Accumulate stage, cleared at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      acc_q <= '0;
        else if (start)  acc_q <= '0;
        else if (acc_en) acc_q <= acc_q + ACC_W'(prod_q);
    end

    // Round half up to Q1.15 and clamp to the 16-bit range.
    always_comb begin
        rounded = (acc_q + HALF) >>> SHIFT;
        sat_val = rounded[15:0];
        if (rounded > SAT_HI)      sat_val = 16'sh7FFF;
        else if (rounded < SAT_LO) sat_val = 16'sh8000;
    end

    // Result register, valid strobe and overrun strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.smpl_out <= '0;
            bus.valid    <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            bus.valid   <= (state_q == DONE);
            bus.overrun <= rise && (state_q != IDLE);
            if (state_q == DONE) bus.smpl_out <= sat_val;
        end
    end
endmodule

// File: tb/tb_fir_tap_engine.sv
// tb/tb_fir_tap_engine.sv - table-driven frame bench with result scoreboard
module tb_fir_tap_engine;
    localparam int N    = 1021;
    localparam int CA_W = 10;
    localparam int LAT  = N + 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fir_tap_engine_if #(.CA_W(CA_W)) bus();

    fir_tap_engine #(.N_TAPS(N), .CA_W(CA_W), .ACC_W(42), .SHIFT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic signed [15:0] coeff_mem [0:1023];
    logic signed [15:0] samp [0:N-1];

    // synchronous coefficient ROM
    always @(posedge clk) bus.coeff <= coeff_mem[bus.coeff_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] val;
        int          id;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          mode;
        int          fall_at;
        int          rise2_at;
        int          abort_at;
        logic [15:0] exp;
        int          exp_ovr;
    } vec_t;
    vec_t vt [0:10];

    int tests = 0;
    int fails = 0;
    int ovr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // output monitor: pops the scoreboard on every valid strobe
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (bus.overrun === 1'b1) ovr_cnt++;
        if (bus.valid === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: smpl_out=%h at cycle %0d, no result expected", bus.smpl_out, cyc);
            end else begin
                e = sb.pop_front();
                if (bus.smpl_out !== e.val || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL frame%0d_result: got %h at cycle %0d, expected %h at cycle %0d",
                             e.id, bus.smpl_out, cyc, e.val, e.cyc);
                end
            end
        end
    end

    function automatic logic [15:0] model();
        longint s = 0;
        longint r;
        for (int k = 0; k < N; k++) s += longint'(samp[k]) * longint'(coeff_mem[k]);
        r = (s + 64'sd16384) >>> 15;
        if (r > 32767)  return 16'h7FFF;
        if (r < -32768) return 16'h8000;
        return r[15:0];
    endfunction

    task automatic setup(input int mode);
        for (int i = 0; i < 1024; i++) coeff_mem[i] = '0;
        for (int i = 0; i < N; i++) samp[i] = 16'($urandom);
        case (mode)
            0: begin coeff_mem[0] = 16'h4000; samp[0] = 16'h2000; end
            1: begin
                for (int i = N - 1; i < 1024; i++) coeff_mem[i] = 16'h7FFF;
                samp[N-1] = 16'h1234;
            end
            2: for (int i = 0; i < N; i++) begin coeff_mem[i] = 16'h7FFF; samp[i] = 16'h7FFF; end
            3: for (int i = 0; i < N; i++) begin coeff_mem[i] = 16'h7FFF; samp[i] = 16'h8000; end
            4: begin coeff_mem[5] = 16'h0001; samp[5] = 16'h4000; end
            5: begin coeff_mem[7] = 16'h4001; samp[7] = 16'hFFFF; end
            6: for (int i = 0; i < N; i++) coeff_mem[i] = 16'($urandom_range(0, 1023) - 512);
            7: for (int i = 0; i < N; i++) begin coeff_mem[i] = 16'h7FFF; samp[i] = 16'h0020; end
            default: ;
        endcase
    endtask

    task automatic run_frame(input vec_t v, input int id);
        int   s;
        exp_t e;
        setup(v.mode);
        @(negedge clk);
        rst_n = 1'b1;
        s = cyc;
        ovr_cnt = 0;
        e.cyc = s + LAT;
        e.val = (v.mode == 6) ? model() : v.exp;
        e.id  = id;
        if (v.abort_at < 0) sb.push_back(e);
        for (int t = 0; t <= N + 6; t++) begin
            if (t > 0) @(negedge clk);
            bus.sequencing = (t < v.fall_at) || (v.rise2_at > 0 && t >= v.rise2_at);
            bus.smpl_in    = (t >= 1 && t <= N) ? samp[t-1] : 16'($urandom);
            #1;
            if (t == 0) chk($sformatf("f%0d_addr_start", id), 32'(bus.coeff_addr), 32'd0);
            if (t == 5) chk($sformatf("f%0d_addr_k5", id), 32'(bus.coeff_addr), 32'd5);
            if (t == N + 2) chk($sformatf("f%0d_addr_hold", id), 32'(bus.coeff_addr), 32'(N - 1));
            if (t == v.abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_smpl_out", 32'(bus.smpl_out), 32'd0);
                chk("abort_valid", 32'(bus.valid), 32'd0);
                chk("abort_overrun", 32'(bus.overrun), 32'd0);
                chk("abort_addr", 32'(bus.coeff_addr), 32'd0);
                bus.sequencing = 1'b1;
                repeat (3) @(negedge clk);
                return;
            end
        end
        bus.sequencing = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk($sformatf("f%0d_overrun_count", id), 32'(ovr_cnt), 32'(v.exp_ovr));
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL f%0d_missing_valid: %0d results outstanding, required 0", id, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        vt[0]  = '{0, 1100, 0,   -1,  16'h1000, 0};
        vt[1]  = '{1, 1100, 0,   -1,  16'h1234, 0};
        vt[2]  = '{2, 1100, 0,   -1,  16'h7FFF, 0};
        vt[3]  = '{3, 1100, 0,   -1,  16'h8000, 0};
        vt[4]  = '{4, 1100, 0,   -1,  16'h0001, 0};
        vt[5]  = '{5, 1100, 0,   -1,  16'hFFFF, 0};
        vt[6]  = '{6, 1100, 0,   -1,  16'h0000, 0};
        vt[7]  = '{7, 10,   0,   -1,  16'h7F9F, 0};
        vt[8]  = '{7, 10,   500, -1,  16'h7F9F, 1};
        vt[9]  = '{0, 1100, 0,   300, 16'h1000, 0};
        vt[10] = '{6, 1100, 0,   -1,  16'h0000, 0};

        rst_n = 1'b0;
        bus.sequencing = 1'b0;
        bus.smpl_in = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_smpl_out", 32'(bus.smpl_out), 32'd0);
        chk("reset_valid", 32'(bus.valid), 32'd0);
        chk("reset_overrun", 32'(bus.overrun), 32'd0);
        chk("reset_addr", 32'(bus.coeff_addr), 32'd0);
        // keep sequencing high through reset so the first frame starts on release
        bus.sequencing = 1'b1;

        for (int i = 0; i <= 10; i++) run_frame(vt[i], i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end
endmodule
